// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter that serialises multi-byte frames into a
// single byte-wide UART transmitter, MSB byte first.
module uart_tx_arb #(
  parameter int unsigned FRAME_BYTES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0,
  input  logic                     req1,
  input  logic [8*FRAME_BYTES-1:0] data0,
  input  logic [8*FRAME_BYTES-1:0] data1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     done0,
  output logic                     done1,
  output logic                     trmt,
  output logic [7:0]               tx_data,
  input  logic                     tx_done,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

  state_e                   state_q, state_d;
  logic [1:0]               byte_idx_q, byte_idx_d;
  logic                     last_q, last_d;
  logic                     owner_q, owner_d;
  logic [8*FRAME_BYTES-1:0] frame_q, frame_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     gnt0_q, gnt0_d;
  logic                     gnt1_q, gnt1_d;
  logic                     done0_q, done0_d;
  logic                     done1_q, done1_d;
  logic                     trmt_q, trmt_d;
  logic                     txd_prev_q;

  logic                     rise;
  logic                     win1;
  logic                     load_byte;
  logic [1:0]               sel;
  logic [7:0]               byte_sel;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    last_d     = last_q;
    owner_d    = owner_q;
    frame_d    = frame_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    trmt_d     = 1'b0;
    load_byte  = 1'b0;
    win1       = 1'b0;
    rise       = tx_done & ~txd_prev_q;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time goes next
          win1       = req1 & (~req0 | ~last_q);
          owner_d    = win1;
          last_d     = win1;
          frame_d    = win1 ? data1 : data0;
          byte_idx_d = '0;
          gnt0_d     = ~win1;
          gnt1_d     = win1;
          trmt_d     = 1'b1;
          load_byte  = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: state_d = WAIT;
      WAIT: begin
        if (rise) begin
          if (byte_idx_q == LAST_IDX) begin
            done0_d = ~owner_q;
            done1_d = owner_q;
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            trmt_d     = 1'b1;
            load_byte  = 1'b1;
            state_d    = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Byte lane chosen from the next-cycle frame/index so tx_data lands with trmt
    sel      = LAST_IDX - byte_idx_d;
    byte_sel = '0;
    for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
      if (sel == 2'(i)) byte_sel = frame_d[8*i +: 8];
    end
    tx_data_d = load_byte ? byte_sel : tx_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      frame_q    <= '0;
      tx_data_q  <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      trmt_q     <= 1'b0;
      txd_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      frame_q    <= frame_d;
      tx_data_q  <= tx_data_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      trmt_q     <= trmt_d;
      txd_prev_q <= tx_done;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign trmt    = trmt_q;
  assign tx_data = tx_data_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb (FRAME_BYTES=2); the bench plays the UART
// transmitter by driving tx_done. Stimulus and checks happen on negedge.
module tb_uart_tx_arb;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] data0, data1;
  logic        gnt0, gnt1, done0, done1, trmt, busy;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [5:0]  outs;

  int checks = 0;
  int errors = 0;

  uart_tx_arb #(.FRAME_BYTES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .data0   (data0),
    .data1   (data1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .done0   (done0),
    .done1   (done1),
    .trmt    (trmt),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .busy    (busy)
  );

  // {gnt0, gnt1, done0, done1, trmt, busy}
  assign outs = {gnt0, gnt1, done0, done1, trmt, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // From a LOAD cycle: UART drops tx_done on load, then raises it when the byte is out
  task automatic byte_done();
    tx_done = 1'b0;
    step();
    tx_done = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    data0 = '0; data1 = '0; tx_done = 1'b0;
    step(); step();
    chk("rst_outs", 32'(outs), 32'h00);
    chk("rst_txdata", 32'(tx_data), 32'h00);

    // Single requester, two-byte frame; payload changed after grant
    rst_n = 1'b1;
    step();
    req0 = 1'b1; data0 = 16'hA55A;
    step();
    chk("t1_gnt", 32'(outs), 32'b100011);
    chk("t1_b0", 32'(tx_data), 32'hA5);
    req0 = 1'b0; data0 = 16'h0000;
    tx_done = 1'b0;
    step();
    chk("t1_wait0", 32'(outs), 32'b000001);
    chk("t1_hold0", 32'(tx_data), 32'hA5);
    tx_done = 1'b1;
    step();
    chk("t1_load1", 32'(outs), 32'b000011);
    chk("t1_b1", 32'(tx_data), 32'h5A);
    byte_done();
    chk("t1_done", 32'(outs), 32'b001000);
    step();
    chk("t1_idle", 32'(outs), 32'h00);

    // Stale tx_done high when trmt fires must not advance
    req0 = 1'b1; data0 = 16'h6789;
    step();
    chk("t4_gnt", 32'(outs), 32'b100011);
    chk("t4_b0", 32'(tx_data), 32'h67);
    req0 = 1'b0;
    step(); step();
    chk("t4_stale", 32'(outs), 32'b000001);
    chk("t4_hold", 32'(tx_data), 32'h67);
    tx_done = 1'b0;
    step();
    chk("t4_low", 32'(outs), 32'b000001);
    tx_done = 1'b1;
    step();
    chk("t4_load1", 32'(outs), 32'b000011);
    chk("t4_b1", 32'(tx_data), 32'h89);
    byte_done();
    chk("t4_done", 32'(outs), 32'b001000);
    step();

    // req1 pulse while frame 0 is in WAIT is withdrawn
    req0 = 1'b1; data0 = 16'h1357; data1 = 16'hFFFF;
    step();
    chk("t5_gnt", 32'(outs), 32'b100011);
    req0 = 1'b0; tx_done = 1'b0;
    step();
    req1 = 1'b1;
    step();
    req1 = 1'b0;
    chk("t5_wait", 32'(outs), 32'b000001);
    tx_done = 1'b1;
    step();
    chk("t5_load1", 32'(outs), 32'b000011);
    chk("t5_b1", 32'(tx_data), 32'h57);
    byte_done();
    chk("t5_done", 32'(outs), 32'b001000);
    step();
    chk("t5_idle0", 32'(outs), 32'h00);
    step();
    chk("t5_idle1", 32'(outs), 32'h00);

    // Tie after reset: req0 first, then req1
    rst_n = 1'b0; tx_done = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    req0 = 1'b1; req1 = 1'b1; data0 = 16'hA55A; data1 = 16'h1234;
    step();
    chk("t2_gnt0", 32'(outs), 32'b100011);
    chk("t2_a5", 32'(tx_data), 32'hA5);
    req0 = 1'b0;
    byte_done();
    chk("t2_5a", 32'(tx_data), 32'h5A);
    byte_done();
    chk("t2_done0", 32'(outs), 32'b001000);
    step();
    chk("t2_gnt1", 32'(outs), 32'b010011);
    chk("t2_12", 32'(tx_data), 32'h12);
    req1 = 1'b0;
    byte_done();
    chk("t2_load34", 32'(outs), 32'b000011);
    chk("t2_34", 32'(tx_data), 32'h34);
    byte_done();
    chk("t2_done1", 32'(outs), 32'b000100);
    step();

    // Both held high for four frames: grants alternate 0,1,0,1
    rst_n = 1'b0; tx_done = 1'b0;
    step();
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1; data0 = 16'hC0DE; data1 = 16'hBEEF;
    step();
    for (int f = 0; f < 4; f++) begin
      if (f % 2 == 0) begin
        chk("t3_gnt0", 32'(outs), 32'b100011);
        chk("t3_c0", 32'(tx_data), 32'hC0);
      end else begin
        chk("t3_gnt1", 32'(outs), 32'b010011);
        chk("t3_be", 32'(tx_data), 32'hBE);
      end
      byte_done();
      chk("t3_load1", 32'(outs), 32'b000011);
      chk("t3_b1", 32'(tx_data), (f % 2 == 0) ? 32'hDE : 32'hEF);
      byte_done();
      chk("t3_done", 32'(outs), (f % 2 == 0) ? 32'b001000 : 32'b000100);
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    byte_done();
    byte_done();
    step();
    chk("t3_quiet", 32'(outs), 32'h00);

    // Reset during the second byte's WAIT aborts silently
    req0 = 1'b1; data0 = 16'hDEAD; tx_done = 1'b0;
    step();
    chk("t6_gnt", 32'(outs), 32'b100011);
    req0 = 1'b0;
    byte_done();
    chk("t6_ad", 32'(tx_data), 32'hAD);
    tx_done = 1'b0;
    step();
    chk("t6_wait", 32'(outs), 32'b000001);
    rst_n = 1'b0;
    step();
    chk("t6_rst_outs", 32'(outs), 32'h00);
    chk("t6_rst_tx", 32'(tx_data), 32'h00);
    rst_n = 1'b1; tx_done = 1'b1;
    step();
    chk("t6_nodone", 32'(outs), 32'h00);
    req0 = 1'b1; data0 = 16'h0F1E;
    step();
    chk("t6_regnt", 32'(outs), 32'b100011);
    chk("t6_0f", 32'(tx_data), 32'h0F);
    req0 = 1'b0;
    byte_done();
    chk("t6_1e", 32'(tx_data), 32'h1E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 2, giving bytes per frame; legal range 1..4.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic on posedge.
REQ-003 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have ports req0 / req1, input, 1 each: requester wants to send a frame.
REQ-005 SHALL have ports data0 / data1, input, 8*FRAME_BYTES each: frame payload, sent MSB byte first.
REQ-006 SHALL have ports gnt0 / gnt1, output, 1 each: one-cycle pulse, frame accepted and payload captured.
REQ-007 SHALL have ports done0 / done1, output, 1 each: one-cycle pulse, last byte of that requester's frame fully transmitted.
REQ-008 SHALL have port trmt, output, 1: one-cycle start pulse to the UART transmitter.
REQ-009 SHALL have port tx_data, output, 8: byte to the UART transmitter, registered.
REQ-010 SHALL have port tx_done, input, 1: transmitter done level, held high until its next load.
REQ-011 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, LOAD, WAIT.
REQ-013 In IDLE with any req high at edge N, SHALL select a winner, capture its data into an internal frame register, clear byte_idx to 0, and enter LOAD at edge N.
REQ-014 SHALL arbitrate round-robin with a last-grant pointer: a single requester wins immediately; with both requesting, the one not last granted wins.
REQ-015 The pointer SHALL reset to "last = 1", so req0 wins the first tie.
REQ-016 In LOAD (exactly one cycle), gntX (first byte only), trmt and tx_data SHALL all be high/valid together. tx_data = frame byte [FRAME_BYTES-1-byte_idx]. The FSM then enters WAIT.
REQ-017 tx_data SHALL hold stable from LOAD through the whole WAIT state.
REQ-018 Byte completion SHALL be a rising edge of tx_done (tx_done high, registered previous value low). A stale high tx_done level on entering LOAD/WAIT SHALL NOT count.
REQ-019 In WAIT on completion:
- if byte_idx < FRAME_BYTES-1: increment byte_idx and enter LOAD (trmt for the next byte).
- else: pulse doneX for one cycle and return to IDLE.
REQ-020 A frame SHALL be atomic: no grant to the other requester until its done pulse.
REQ-021 There SHALL be a minimum of one IDLE cycle between doneX and the next gnt.
REQ-022 Latency SHALL be one cycle from req sampled in IDLE to gnt/trmt.
REQ-023 A req dropped before its grant edge SHALL be withdrawn with no side effects.
REQ-024 A req still high after its done SHALL be treated as a new request and arbitrated normally against the other requester.
REQ-025 dataX changes after gnt SHALL NOT affect the frame in flight.
REQ-026 Exactly one gnt, and later exactly one done, SHALL be pulsed per accepted frame; gnt0/gnt1 and done0/done1 are never simultaneously high.
REQ-027 byte_idx width SHALL be 2 bits; it never wraps past FRAME_BYTES-1.

Reset
REQ-028 On rst_n low at a clock edge:
- state = IDLE; byte_idx = 0; pointer = last 1.
- gnt0, gnt1, done0, done1, trmt, busy = 0; tx_data = 8'h00; tx_done edge register = 0.
REQ-029 Reset mid-frame SHALL abort the frame silently with no done pulse.
REQ-030 The controller and the UART transmitter share rst_n; the controller need not track a transmission in flight across reset.

Verification
REQ-031 FRAME_BYTES=2, req0=1, data0=16'hA55A -> gnt0 and trmt with tx_data=8'hA5 one cycle later. After the tx_done rise -> trmt with 8'h5A. After the second rise -> done0 pulse, busy=0.
REQ-032 After reset, req0 and req1 rise the same cycle with data1=16'h1234 -> frame 0 completes first (gnt0, done0), then gnt1, tx_data 8'h12 then 8'h34, done1.
REQ-033 Both reqs held high for 4 frames -> grants alternate 0,1,0,1; never two gnts without an intervening done.
REQ-034 tx_done held high from a prior byte when trmt fires -> no advance until tx_done falls and rises again.
REQ-035 req1 pulsed for one cycle while frame 0 is in WAIT -> no gnt1 ever issued.
REQ-036 rst_n low during the second byte's WAIT -> all outputs 0 next cycle, no done0, and the FSM accepts a new req0 normally afterwards.
